// File: rtl/isa_bus_pkg.sv
// Shared types and constants for the ISA bus initiator and the video adapters behind it.
package isa_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_HOLD
  } state_e;

  // Bit index into the active-low strobe vector, encoded as {io, write}
  typedef enum logic [1:0] {
    CYC_MEMR = 2'b00,
    CYC_MEMW = 2'b01,
    CYC_IOR  = 2'b10,
    CYC_IOW  = 2'b11
  } cyc_e;

  localparam logic [15:0] CGA_BASE = 16'h03D0;
  localparam logic [15:0] MDA_BASE = 16'h03B0;

  localparam logic [3:0] REG_MODE    = 4'h8;
  localparam logic [3:0] REG_COLOUR  = 4'h9;
  localparam logic [3:0] REG_STATUS  = 4'hA;
  localparam logic [3:0] REG_PALETTE = 4'hE;

  function automatic cyc_e cyc_type(input logic io, input logic write);
    return cyc_e'({io, write});
  endfunction

  function automatic logic [3:0] strobe_lo(input cyc_e c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/isa_bus_master.sv
// ISA bus initiator: one CPU request becomes one setup/strobe/wait/hold cycle with a
// single-cycle response carrying read data or a timeout flag.
//
// state  | meaning
// IDLE   | bus parked (AEN high), ready for a request
// SETUP  | address/AEN/write data settling before the strobe
// STROBE | strobe low for the minimum width, bus_rdy ignored until the last cycle
// WAIT   | strobe held low until bus_rdy or the timeout count expires
// HOLD   | strobe high, address/data held; response pulses in the last cycle
module isa_bus_master
  import isa_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_MIN  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned RDY_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_io,
  input  logic        req_write,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic [19:0] bus_a,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_in,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic        bus_aen,
  input  logic        bus_rdy,
  output logic        busy
);

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_MIN - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] RDY_LD    = 8'(RDY_TIMEOUT - 1);

  state_e     state;
  logic [7:0] cnt;
  logic [3:0] strb_l;
  logic       io_q;
  logic       wr_q;
  logic       tmo_flag;
  logic       to_hold;
  logic       tmo_now;

  always_comb begin
    to_hold = 1'b0;
    tmo_now = 1'b0;
    case (state)
      ST_STROBE: to_hold = (cnt == 8'd0) && bus_rdy;
      ST_WAIT: begin
        to_hold = bus_rdy || (cnt == 8'd0);
        tmo_now = !bus_rdy && (cnt == 8'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      strb_l      <= 4'hF;
      io_q        <= 1'b0;
      wr_q        <= 1'b0;
      tmo_flag    <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      bus_aen     <= 1'b1;
      bus_a       <= 20'd0;
      bus_d_out   <= 8'd0;
      bus_d_oe    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'd0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            io_q      <= req_io;
            wr_q      <= req_write;
            bus_a     <= req_addr;
            bus_aen   <= 1'b0;
            if (req_write) begin
              bus_d_out <= req_wdata;
              bus_d_oe  <= 1'b1;
            end
            cnt       <= SETUP_LD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == 8'd0) begin
            strb_l <= strobe_lo(cyc_type(io_q, wr_q));
            cnt    <= STROBE_LD;
            state  <= ST_STROBE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_STROBE, ST_WAIT: begin
          if (to_hold) begin
            strb_l   <= 4'hF;
            cnt      <= HOLD_LD;
            tmo_flag <= tmo_now;
            state    <= ST_HOLD;
            if (!wr_q) rsp_rdata <= tmo_now ? 8'hFF : bus_d_in;
            // Registered response must already be up in the first HOLD cycle when it is also the last
            if (HOLD_CYC == 1) begin
              rsp_valid   <= 1'b1;
              rsp_timeout <= tmo_now;
            end
          end else if (state == ST_STROBE && cnt == 8'd0) begin
            cnt   <= RDY_LD;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 8'd0) begin
            bus_aen   <= 1'b1;
            bus_d_oe  <= 1'b0;
            tmo_flag  <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              rsp_valid   <= 1'b1;
              rsp_timeout <= tmo_flag;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus_memr_l = strb_l[CYC_MEMR];
  assign bus_memw_l = strb_l[CYC_MEMW];
  assign bus_ior_l  = strb_l[CYC_IOR];
  assign bus_iow_l  = strb_l[CYC_IOW];

endmodule

// File: tb/tb_isa_bus_master.sv
// Bench for isa_bus_master: vector table of single cycles, scoreboarded responses,
// plus mid-cycle reset and back-to-back sequences.
module tb_isa_bus_master;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        req_valid, req_io, req_write;
  logic        req_ready;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [19:0] bus_a;
  logic [7:0]  bus_d_out, bus_d_in;
  logic        bus_d_oe;
  logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
  logic        bus_aen, bus_rdy, busy;

  isa_bus_master #(
    .SETUP_CYC(1), .STROBE_MIN(4), .HOLD_CYC(1), .RDY_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset_l(reset_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_io(req_io), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .bus_a(bus_a), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
    .bus_aen(bus_aen), .bus_rdy(bus_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        io;
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          rdy_low;
    int          exp_len;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    logic       timeout;
  } exp_t;

  int         tests = 0;
  int         fails = 0;
  exp_t       sb_q[$];
  logic [7:0] last_rdata = 8'h00;
  vec_t       vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic wr, input logic to, input logic [7:0] din);
    exp_t e;
    if (!wr) last_rdata = to ? 8'hFF : din;
    e.rdata   = last_rdata;
    e.timeout = to;
    sb_q.push_back(e);
  endtask

  // Scoreboard pop plus one-strobe-at-a-time checker
  always @(negedge clk) begin : mon
    logic [3:0] s;
    exp_t e;
    s = {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l};
    chk("strobe_excl", {31'd0, ($countones(~s) <= 1) && (s == 4'hF || busy)}, 32'd1);
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.timeout});
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int sel, low_sel, low_other, first_low, rsp_cyc, oe_cnt, aen_low, rdy_low_cnt, m;
    logic [3:0] s;
    bit done;
    sel = {30'd0, v.io, v.wr};
    low_sel = 0; low_other = 0; first_low = 0; rsp_cyc = 0;
    oe_cnt = 0; aen_low = 0; rdy_low_cnt = 0; m = 0; done = 0;
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_io = v.io; req_write = v.wr;
    req_addr = v.addr; req_wdata = v.wdata;
    bus_rdy = 1'b1; bus_d_in = v.din;
    push_exp(v.wr, v.exp_to, v.din);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      s = {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l};
      if (rsp_cyc != 0) begin
        chk({tag, ".idle_aen"}, {31'd0, bus_aen}, 32'd1);
        chk({tag, ".idle_oe"}, {31'd0, bus_d_oe}, 32'd0);
        chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".idle_strb"}, {28'd0, s}, 32'hF);
        chk({tag, ".idle_a"}, {12'd0, bus_a}, {12'd0, v.addr});
        done = 1;
        break;
      end
      if (!s[sel]) begin
        low_sel++; m++;
        if (first_low == 0) first_low = k;
      end
      low_other += $countones(~s) - (s[sel] ? 0 : 1);
      if (bus_d_oe) oe_cnt++;
      if (!bus_aen) aen_low++;
      if (!req_ready) rdy_low_cnt++;
      if (rsp_valid) begin
        rsp_cyc = k;
        chk({tag, ".bus_a"}, {12'd0, bus_a}, {12'd0, v.addr});
        if (v.wr) chk({tag, ".d_out"}, {24'd0, bus_d_out}, {24'd0, v.wdata});
      end
      bus_rdy  = !(m > 0 && m <= v.rdy_low);
      bus_d_in = bus_rdy ? v.din : ~v.din;
    end
    if (!done) chk({tag, ".rsp_bound"}, 32'd0, 32'd1);
    chk({tag, ".first_low"}, first_low, 32'd2);
    chk({tag, ".strobe_len"}, low_sel, v.exp_len);
    chk({tag, ".wrong_strobe"}, low_other, 32'd0);
    chk({tag, ".rsp_cycle"}, rsp_cyc, v.exp_len + 2);
    chk({tag, ".oe_cycles"}, oe_cnt, v.wr ? v.exp_len + 2 : 0);
    chk({tag, ".aen_low"}, aen_low, v.exp_len + 2);
    chk({tag, ".ready_low"}, rdy_low_cnt, v.exp_len + 2);
    bus_rdy = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".strobes"}, {28'd0, bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l}, 32'hF);
    chk({tag, ".aen"}, {31'd0, bus_aen}, 32'd1);
    chk({tag, ".bus_a"}, {12'd0, bus_a}, 32'd0);
    chk({tag, ".d_out"}, {24'd0, bus_d_out}, 32'd0);
    chk({tag, ".d_oe"}, {31'd0, bus_d_oe}, 32'd0);
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
    chk({tag, ".rsp_timeout"}, {31'd0, rsp_timeout}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual expired required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, n_acc, rdy_low6;
    bit d2_ok;
    vecs[0] = '{1'b1, 1'b1, 20'h003D8, 8'h09, 8'h00, 0,  4,  1'b0};
    vecs[1] = '{1'b1, 1'b0, 20'h003DA, 8'h00, 8'hF9, 0,  4,  1'b0};
    vecs[2] = '{1'b0, 1'b0, 20'hB8000, 8'h00, 8'h5A, 10, 11, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 20'hB8001, 8'h00, 8'h33, 20, 12, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 20'hB0000, 8'hC3, 8'h00, 3,  4,  1'b0};
    vecs[5] = '{1'b1, 1'b1, 20'h003B8, 8'h29, 8'h00, 5,  6,  1'b0};
    vecs[6] = '{1'b1, 1'b0, 20'h003BA, 8'h00, 8'h77, 11, 12, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 20'hB8002, 8'hA5, 8'h00, 30, 12, 1'b1};

    reset_l = 1'b0; req_valid = 1'b0; req_io = 1'b0; req_write = 1'b0;
    req_addr = 20'd0; req_wdata = 8'd0; bus_d_in = 8'd0; bus_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_l = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a strobe: abandoned cycle, no response
    @(negedge clk);
    req_valid = 1'b1; req_io = 1'b1; req_write = 1'b1; req_addr = 20'h003D9; req_wdata = 8'h5C;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid.strobe_low", {31'd0, bus_iow_l}, 32'd0);
    #2;
    reset_l = 1'b0;
    #1;
    chk_reset_vals("mid");
    last_rdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("mid.no_rsp", {31'd0, rsp_valid}, 32'd0);
    reset_l = 1'b1;
    run_vec(vecs[0], "post_reset");

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_valid = 1'b1; req_io = 1'b1; req_write = 1'b1; req_addr = 20'h003D9; req_wdata = 8'h11;
    bus_rdy = 1'b1;
    push_exp(1'b1, 1'b0, 8'h00);
    push_exp(1'b1, 1'b0, 8'h00);
    a1 = -1; a2 = -1; n_acc = 0; rdy_low6 = 0; d2_ok = 0;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 1 && k <= 6 && !req_ready) rdy_low6++;
      if (k == 10) d2_ok = (bus_d_out == 8'h22) && bus_d_oe;
      if (req_valid && req_ready) begin
        if (n_acc == 0) a1 = k; else if (n_acc == 1) a2 = k;
        n_acc++;
      end
      if (k == 1) req_wdata = 8'h22;
      if (n_acc >= 2 && k > a2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("b2b.accept1", a1, 32'd0);
    chk("b2b.accept2", a2, 32'd7);
    chk("b2b.accepts", n_acc, 32'd2);
    chk("b2b.ready_low", rdy_low6, 32'd6);
    chk("b2b.second_data", {31'd0, d2_ok}, 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
